// File: rtl/kat_adc_config_sequencer.sv
// Replays a table of KAT ADC 3-wire register writes and arbitrates single software writes.
// Optional BUSY watchdog: define KATADC_SEQ_WATCHDOG_EN.
`timescale 1ns/1ps
module kat_adc_config_sequencer #(
  parameter  int NUM_ENTRIES  = 8,
  parameter  int POWERUP_WAIT = 1024,
  parameter  int AUTOCONFIG   = 0,
  parameter  int ARM_TIMEOUT  = 7,
  parameter  int WDOG_CYCLES  = 4096,
  localparam int IDX_W        = $clog2(NUM_ENTRIES)
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             tbl_we,
  input  logic [IDX_W-1:0] tbl_addr,
  input  logic [19:0]      tbl_data,
  input  logic [IDX_W:0]   seq_len,
  input  logic             run,
  input  logic             sw_req,
  input  logic [3:0]       sw_addr,
  input  logic [15:0]      sw_data,
  output logic             sw_ack,
  output logic             cfg_start,
  output logic [3:0]       cfg_addr,
  output logic [15:0]      cfg_data,
  input  logic             cfg_done,
  output logic             seq_busy,
  output logic             seq_done,
  output logic             seq_err
);

  localparam int CNT_MAX_A = (POWERUP_WAIT > ARM_TIMEOUT) ? POWERUP_WAIT : ARM_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > WDOG_CYCLES) ? CNT_MAX_A : WDOG_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PWRUP, S_FETCH, S_ISSUE, S_ARM, S_BUSY, S_NEXT
  } state_t;

  state_t           state, state_nx;
  logic [19:0]      ram [NUM_ENTRIES];
  logic [IDX_W:0]   idx, len, len_sat;
  logic [CNT_W-1:0] cnt;
  logic             src_sw, pwrup_pend;
  logic             start_tbl, start_sw, fetch_load, idx_inc, set_done, set_err;

  assign len_sat  = (seq_len > (IDX_W+1)'(NUM_ENTRIES)) ? (IDX_W+1)'(NUM_ENTRIES) : seq_len;
  assign seq_busy = (state != S_IDLE);

  // NOTE: the table RAM has no reset so it maps onto block/distributed RAM; contents survive reset.
  always_ff @(posedge wb_clk_i) begin
    if (tbl_we && state == S_IDLE) ram[tbl_addr] <= tbl_data;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_nx   = state;
    start_tbl  = 1'b0;
    start_sw   = 1'b0;
    fetch_load = 1'b0;
    idx_inc    = 1'b0;
    set_done   = 1'b0;
    set_err    = 1'b0;
    cfg_start  = 1'b0;
    sw_ack     = 1'b0;
    case (state)
      S_IDLE: begin
        if (pwrup_pend) begin
          state_nx = S_PWRUP;
        end else if (run) begin
          state_nx  = S_FETCH;
          start_tbl = 1'b1;
        end else if (sw_req) begin
          state_nx = S_ISSUE;
          start_sw = 1'b1;
        end
      end
      S_PWRUP: begin
        if (cnt == CNT_W'(POWERUP_WAIT - 1)) begin
          state_nx  = S_FETCH;
          start_tbl = 1'b1;
        end
      end
      S_FETCH: begin
        if (idx == len) begin
          set_done = 1'b1;
          state_nx = S_IDLE;
        end else begin
          fetch_load = 1'b1;
          state_nx   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cfg_start = 1'b1;
        state_nx  = S_ARM;
      end
      S_ARM: begin
        if (!cfg_done) begin
          state_nx = S_BUSY;
        end else if (cnt == CNT_W'(ARM_TIMEOUT - 1)) begin
          // A table replay is abandoned; a software write is still acknowledged.
          set_err  = 1'b1;
          state_nx = src_sw ? S_NEXT : S_IDLE;
        end
      end
      S_BUSY: begin
        if (cfg_done) begin
          state_nx = S_NEXT;
        end
`ifdef KATADC_SEQ_WATCHDOG_EN
        else if (cnt == CNT_W'(WDOG_CYCLES - 1)) begin
          set_err  = 1'b1;
          state_nx = src_sw ? S_NEXT : S_IDLE;
        end
`endif
      end
      S_NEXT: begin
        if (src_sw) begin
          sw_ack   = 1'b1;
          state_nx = S_IDLE;
        end else begin
          idx_inc  = 1'b1;
          state_nx = S_FETCH;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= S_IDLE;
      pwrup_pend <= (AUTOCONFIG != 0);
      cnt        <= '0;
      idx        <= '0;
      len        <= '0;
      src_sw     <= 1'b0;
      cfg_addr   <= '0;
      cfg_data   <= '0;
      seq_done   <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= (state_nx != state) ? '0 : cnt + 1'b1;
      if (state == S_IDLE) pwrup_pend <= 1'b0;
      if (start_tbl) begin
        idx      <= '0;
        len      <= len_sat;
        src_sw   <= 1'b0;
        seq_done <= 1'b0;
        seq_err  <= 1'b0;
      end
      if (start_sw) begin
        src_sw   <= 1'b1;
        cfg_addr <= sw_addr;
        cfg_data <= sw_data;
      end
      if (fetch_load) {cfg_addr, cfg_data} <= ram[idx[IDX_W-1:0]];
      if (idx_inc) idx <= idx + 1'b1;
      if (set_done) seq_done <= 1'b1;
      if (set_err) seq_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_kat_adc_config_sequencer.sv
// Scoreboard bench: stimulus queues expected engine writes, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_kat_adc_config_sequencer;

  localparam int NE = 8;
  localparam int IW = 3;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i = 1'b1;
  logic          tbl_we = 1'b0;
  logic [IW-1:0] tbl_addr = '0;
  logic [19:0]   tbl_data = '0;
  logic [IW:0]   seq_len = '0;
  logic          run = 1'b0;
  logic          sw_req = 1'b0;
  logic [3:0]    sw_addr = '0;
  logic [15:0]   sw_data = '0;
  logic          sw_ack, cfg_start, cfg_done, seq_busy, seq_done, seq_err;
  logic [3:0]    cfg_addr;
  logic [15:0]   cfg_data;

  kat_adc_config_sequencer #(
    .NUM_ENTRIES(NE), .POWERUP_WAIT(16), .AUTOCONFIG(1), .ARM_TIMEOUT(7), .WDOG_CYCLES(64)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_data(tbl_data), .seq_len(seq_len), .run(run), .sw_req(sw_req), .sw_addr(sw_addr),
    .sw_data(sw_data), .sw_ack(sw_ack), .cfg_start(cfg_start), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_done(cfg_done), .seq_busy(seq_busy), .seq_done(seq_done),
    .seq_err(seq_err)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  logic [19:0] tbl [NE];
  logic [19:0] exp_q [$];
  int n_checks = 0, n_pass = 0;
  int cyc = 0, first_start = -1, last_start = -1, last_rise = -1;
  int n_acks = 0, exp_acks = 0;
  logic done_q = 1'b1;

  // Engine model: 0 = normal (done low 40 cycles), 1 = never drops cfg_done.
  int eng_mode = 0;
  int eng_cnt = 0;
  assign cfg_done = (eng_mode == 1) ? 1'b1 : (eng_cnt == 0);
  always @(posedge wb_clk_i) begin
    if (cfg_start && eng_mode == 0) eng_cnt <= 40;
    else if (eng_cnt != 0) eng_cnt <= eng_cnt - 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  always @(negedge wb_clk_i) begin
    if (wb_rst_i) cyc = 0;
    else cyc++;
    if (cfg_done && !done_q) last_rise = cyc;
    done_q = cfg_done;
    if (cfg_start) begin
      last_start = cyc;
      if (first_start < 0) first_start = cyc;
      if (exp_q.size() == 0) check("start_expected", exp_q.size(), 1);
      else check("cfg_write", {cfg_addr, cfg_data}, exp_q.pop_front());
    end
    if (sw_ack) begin
      n_acks++;
      check("ack_after_done", cyc - last_rise, 1);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge wb_clk_i);
      #1;
    end
  endtask

  task automatic pulse_run();
    run = 1'b1;
    tick(1);
    run = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    int k = 0;
    while (!seq_done && k < bound) begin
      tick(1);
      k++;
    end
    check(name, seq_done, 1);
  endtask

  task automatic wait_ack(input string name, input int bound);
    int k = 0;
    do begin
      tick(1);
      k++;
    end while (!sw_ack && k < bound);
    check(name, sw_ack, 1);
    sw_req = 1'b0;
  endtask

  task automatic push_tbl(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(tbl[i]);
  endtask

  initial begin
    int err_cyc;
    tbl[0] = {4'h1, 16'h00AA};
    tbl[1] = {4'h2, 16'h1234};
    tbl[2] = {4'hF, 16'hFFFF};
    for (int i = 3; i < NE; i++) tbl[i] = 20'(32'h30000 + i * 32'h1111);

    tick(2);
    check("reset_outputs", {cfg_start, sw_ack, seq_busy, seq_done, seq_err, cfg_addr, cfg_data}, 0);

    // The sequencer sits in IDLE while reset is held, so the table loads before auto replay.
    for (int i = 0; i < NE; i++) begin
      tbl_we = 1'b1;
      tbl_addr = IW'(i);
      tbl_data = tbl[i];
      tick(1);
    end
    tbl_we = 1'b0;

    // Auto replay after the power-up wait.
    seq_len = 4'd3;
    push_tbl(3);
    wb_rst_i = 1'b0;
    tick(3);
    check("pwrup_busy", seq_busy, 1);
    check("pwrup_no_start", exp_q.size(), 3);
    wait_done("auto_done", 1000);
    check("auto_idle", seq_busy, 0);
    check("pwrup_delay_ok", first_start >= 16, 1);
    check("auto_queue_empty", exp_q.size(), 0);

    // Single software write.
    exp_q.push_back({4'h5, 16'hBEEF});
    exp_acks++;
    sw_addr = 4'h5;
    sw_data = 16'hBEEF;
    sw_req = 1'b1;
    wait_ack("sw_ack_seen", 200);
    tick(2);
    check("sw_ack_count", n_acks, exp_acks);

    // run and sw_req together: table first, then the software write.
    seq_len = 4'd2;
    push_tbl(2);
    exp_q.push_back({4'h7, 16'h0123});
    exp_acks++;
    sw_addr = 4'h7;
    sw_data = 16'h0123;
    sw_req = 1'b1;
    pulse_run();
    wait_ack("arb_ack_seen", 400);
    tick(2);
    check("arb_done", seq_done, 1);
    check("arb_ack_count", n_acks, exp_acks);
    check("arb_queue_empty", exp_q.size(), 0);

    // Engine never drops cfg_done: timeout eight cycles after cfg_start.
    eng_mode = 1;
    seq_len = 4'd1;
    push_tbl(1);
    pulse_run();
    begin
      int k = 0;
      while (!seq_err && k < 30) begin
        tick(1);
        k++;
      end
    end
    err_cyc = cyc;
    check("timeout_err", seq_err, 1);
    check("timeout_delay", err_cyc - last_start, 8);
    check("timeout_idle", seq_busy, 0);
    check("timeout_no_done", seq_done, 0);
    eng_mode = 0;
    tick(2);

    // seq_len=0: run clears seq_err, completes with no cfg_start.
    seq_len = 4'd0;
    pulse_run();
    check("run_clears_err", seq_err, 0);
    wait_done("len0_done", 2);
    check("len0_idle", seq_busy, 0);

    // Table writes during a replay are dropped.
    seq_len = 4'd3;
    push_tbl(3);
    pulse_run();
    tick(5);
    tbl_we = 1'b1;
    tbl_addr = 3'd1;
    tbl_data = 20'hAAAAA;
    tick(1);
    tbl_we = 1'b0;
    wait_done("we_replay_done", 500);
    push_tbl(3);
    pulse_run();
    wait_done("we_recheck_done", 500);
    check("we_queue_empty", exp_q.size(), 0);

    // Saturation: seq_len beyond the table depth replays all entries.
    seq_len = 4'd15;
    push_tbl(NE);
    pulse_run();
    wait_done("sat_done", 1000);
    check("sat_queue_empty", exp_q.size(), 0);

    // Asynchronous reset while the engine is shifting.
    seq_len = 4'd1;
    push_tbl(1);
    pulse_run();
    tick(10);
    check("pre_reset_busy", {seq_busy, cfg_done}, 2'b10);
    #2 wb_rst_i = 1'b1;
    #1;
    check("async_reset_outputs",
          {cfg_start, sw_ack, seq_busy, seq_done, seq_err, cfg_addr, cfg_data}, 0);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_ack_count", n_acks, exp_acks);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
